// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and arithmetic helpers for the LIF neuron array
package lif_pkg;

    localparam int LEAK_W = 3;

    // V - L + I at full precision, clamped to the largest mem_w-bit value
    function automatic int unsigned sat_add(input int unsigned v, input int unsigned l,
                                            input int unsigned i, input int unsigned mem_w);
        int unsigned s;
        int unsigned top;
        s = v - l + i;
        top = (32'd1 << mem_w) - 32'd1;
        return (s > top) ? top : s;
    endfunction

    // lowest bit of channel k in a packed bus of w-bit lanes
    function automatic int unsigned chan_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// lif_neuron: one leaky integrate-and-fire channel updated on prescaler ticks
module lif_neuron
    import lif_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int MEM_W  = 10,
    parameter int REFR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              clear,
    input  logic [IN_W-1:0]   i_cur,
    input  logic [MEM_W-1:0]  cfg_thresh,
    input  logic [LEAK_W-1:0] cfg_leak,
    input  logic [REFR_W-1:0] cfg_refr,
    output logic              spike,
    output logic [MEM_W-1:0]  v
);

    logic [MEM_W-1:0]  v_q, v_d, leak, sum;
    logic [REFR_W-1:0] refr_q, refr_d;
    logic              spike_q, spike_d, fire, in_refr;

    // next membrane, refractory count and spike; state only moves on a tick
    always_comb begin
        leak    = (cfg_leak == '0) ? '0 : v_q >> cfg_leak;
        sum     = MEM_W'(sat_add(32'(v_q), 32'(leak), 32'(i_cur), MEM_W));
        in_refr = refr_q != '0;
        fire    = !in_refr && sum >= cfg_thresh;
        spike_d = tick && fire;
        v_d     = !tick ? v_q : (in_refr || fire) ? '0 : sum;
        refr_d  = !tick ? refr_q : in_refr ? refr_q - REFR_W'(1) : fire ? cfg_refr : refr_q;
    end

    // channel state registers; soft clear behaves like reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else if (clear) begin
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;
    assign v     = v_q;

endmodule

// File: rtl/lif_array.sv
// lif_array: bank of LIF neurons sharing a programmable tick prescaler
module lif_array
    import lif_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int IN_W   = 8,
    parameter int MEM_W  = 10,
    parameter int DIV_W  = 23,
    parameter int REFR_W = 3,
    parameter int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clear,
    input  logic [N_CH*IN_W-1:0] i_cur,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [MEM_W-1:0]   cfg_thresh,
    input  logic [LEAK_W-1:0]  cfg_leak,
    input  logic [REFR_W-1:0]  cfg_refr,
    input  logic [SEL_W-1:0]   mem_sel,
    output logic [N_CH-1:0]    spike,
    output logic               tick,
    output logic [MEM_W-1:0]   mem_out
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_int, tick_q;
    logic [MEM_W-1:0] v [N_CH];

    // prescaler: >= compare so lowering cfg_div mid-count ticks at once instead of wrapping
    always_comb begin
        tick_int  = en && div_cnt_q >= cfg_div;
        div_cnt_d = !en ? div_cnt_q : tick_int ? '0 : div_cnt_q + DIV_W'(1);
    end

    // prescaler state and registered tick, aligned with the neuron spike outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else if (clear) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_int;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        lif_neuron #(
            .IN_W  (IN_W),
            .MEM_W (MEM_W),
            .REFR_W(REFR_W)
        ) u_neuron (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick_int),
            .clear     (clear),
            .i_cur     (i_cur[chan_lo(k, IN_W) +: IN_W]),
            .cfg_thresh(cfg_thresh),
            .cfg_leak  (cfg_leak),
            .cfg_refr  (cfg_refr),
            .spike     (spike[k]),
            .v         (v[k])
        );
    end

    assign tick    = tick_q;
    assign mem_out = v[mem_sel];

endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: scoreboard bench with a behavioural neuron model for lif_array
module tb_lif_array;

    localparam int N = 4, IW = 8, MW = 10, DW = 23, RW = 3;
    localparam int VMAX = (1 << MW) - 1;

    logic            clk = 1'b0;
    logic            rst_n, en, clear;
    logic [N*IW-1:0] i_cur;
    logic [DW-1:0]   cfg_div;
    logic [MW-1:0]   cfg_thresh;
    logic [2:0]      cfg_leak;
    logic [RW-1:0]   cfg_refr;
    logic [1:0]      mem_sel;
    logic [N-1:0]    spike;
    logic            tick;
    logic [MW-1:0]   mem_out;

    typedef struct {
        logic         tick;
        logic [N-1:0] spike;
        int           mem;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   m_cnt, m_v[N], m_r[N];
    int   mon_ticks, first_spk;

    always #5 clk = ~clk;

    lif_array #(
        .N_CH(N), .IN_W(IW), .MEM_W(MW), .DIV_W(DW), .REFR_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .i_cur(i_cur),
        .cfg_div(cfg_div), .cfg_thresh(cfg_thresh), .cfg_leak(cfg_leak),
        .cfg_refr(cfg_refr), .mem_sel(mem_sel), .spike(spike), .tick(tick),
        .mem_out(mem_out)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int k = 0; k < N; k++) begin
            m_v[k] = 0;
            m_r[k] = 0;
        end
    endtask

    // predict the result of the coming clock edge, queue it, then advance to the next negedge
    task automatic cycle();
        exp_t e;
        int   s, cur;
        e.tick  = 1'b0;
        e.spike = '0;
        if (clear) model_reset();
        else if (en) begin
            m_cnt++;
            if (m_cnt > int'(cfg_div)) begin
                m_cnt  = 0;
                e.tick = 1'b1;
                for (int k = 0; k < N; k++) begin
                    cur = int'(i_cur[k*IW +: IW]);
                    if (m_r[k] > 0) begin
                        m_r[k]--;
                        m_v[k] = 0;
                    end else begin
                        s = m_v[k] - ((cfg_leak == 0) ? 0 : (m_v[k] >> cfg_leak)) + cur;
                        if (s > VMAX) s = VMAX;
                        if (s >= int'(cfg_thresh)) begin
                            e.spike[k] = 1'b1;
                            m_v[k] = 0;
                            m_r[k] = int'(cfg_refr);
                        end else m_v[k] = s;
                    end
                end
            end
        end
        e.mem = m_v[mem_sel];
        q.push_back(e);
        @(negedge clk);
    endtask

    // monitor: compare every registered output against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("tick", int'(tick), int'(e.tick));
                check("spike", int'(spike), int'(e.spike));
                check("mem_out", int'(mem_out), e.mem);
                if (tick) mon_ticks++;
                if (spike[0] && first_spk == 0) first_spk = mon_ticks;
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; i_cur = '0; cfg_div = '0;
        cfg_thresh = '0; cfg_leak = '0; cfg_refr = '0; mem_sel = '0;
        mon_ticks = 0; first_spk = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_tick", int'(tick), 0);
        check("reset_spike", int'(spike), 0);
        check("reset_mem", int'(mem_out), 0);
        rst_n = 1'b1;

        // integration with period-4 spikes, then refractory stretch
        en = 1'b1; cfg_thresh = 100; i_cur = 32'd30;
        repeat (12) cycle();
        cfg_refr = 2;
        repeat (18) cycle();

        // leak convergence to 160 without firing
        clear = 1'b1; cycle(); clear = 1'b0;
        cfg_refr = 0; cfg_leak = 2; cfg_thresh = 200; i_cur = 32'd40;
        repeat (40) cycle();
        check("leak_settle", int'(mem_out), 160);

        // leak with lower threshold: first spike tick
        clear = 1'b1; cycle(); clear = 1'b0;
        mon_ticks = 0; first_spk = 0; cfg_thresh = 150;
        repeat (14) cycle();
        check("leak_first_spike_tick", first_spk, 10);

        // saturation at 1023 with no wrap
        clear = 1'b1; cycle(); clear = 1'b0;
        mon_ticks = 0; first_spk = 0; cfg_leak = 0; cfg_thresh = 1023; i_cur = 32'd255;
        repeat (4) cycle();
        check("sat_before", int'(mem_out), 1020);
        repeat (4) cycle();
        check("sat_spike_tick", first_spk, 5);

        // prescaler, en gating, mid-count divider lowering
        clear = 1'b1; cycle(); clear = 1'b0;
        cfg_div = 3; cfg_thresh = 1000; i_cur = 32'h0A0A_0A0A;
        repeat (12) cycle();
        en = 1'b0; repeat (5) cycle(); en = 1'b1;
        repeat (6) cycle();
        for (int j = 0; j < 8 && m_cnt != 2; j++) cycle();
        cfg_div = 1;
        cycle();
        check("div_lower_tick", int'(tick), 1);
        repeat (6) cycle();

        // async reset between edges, then clear at an edge
        clear = 1'b1; cycle(); clear = 1'b0;
        cfg_div = 0; cfg_thresh = 100; i_cur = 32'd30; mem_sel = 0;
        repeat (3) cycle();
        check("pre_reset_mem", int'(mem_out), 90);
        #2 rst_n = 1'b0;
        #1;
        check("async_mem", int'(mem_out), 0);
        check("async_tick", int'(tick), 0);
        check("async_spike", int'(spike), 0);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (6) cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clear_mem", int'(mem_out), 0);
        repeat (4) cycle();

        // randomized configuration and currents
        repeat (600) begin
            en         = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 49) == 0);
            i_cur      = $urandom;
            cfg_div    = DW'($urandom_range(0, 3));
            cfg_thresh = MW'($urandom_range(0, 1023));
            cfg_leak   = 3'($urandom_range(0, 7));
            cfg_refr   = RW'($urandom_range(0, 7));
            mem_sel    = 2'($urandom_range(0, 3));
            cycle();
        end
        clear = 1'b0;

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
